// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with bubble/flush/hold control
// Optional perf counters enabled by `define ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int          CNT_W  = 20,
  parameter logic [31:0] PC_RST = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             flush,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_r1_data,
  input  logic [31:0]      id_r2_data,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_wa,
  input  logic             id_we,
  input  logic [1:0]       id_cregwd,
  input  logic [3:0]       id_aluop,
  input  logic             id_memwe,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_r1_data,
  output logic [31:0]      ex_r2_data,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_wa,
  output logic             ex_we,
  output logic [1:0]       ex_cregwd,
  output logic [3:0]       ex_aluop,
  output logic             ex_memwe,
  output logic             stall_if,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
);

  typedef enum logic [1:0] {RUN, HOLD, HOLD_FL} state_t;

  state_t state, state_nxt;
  logic   load, bubble, flush_eff;

  assign stall_if = pause | hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hold) state_nxt = flush ? HOLD_FL : HOLD;
      HOLD:    if (!hold) state_nxt = RUN;
               else if (flush) state_nxt = HOLD_FL;
      HOLD_FL: if (!hold) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // A flush queued during a hold is applied on the release cycle.
  always_comb begin
    load      = !hold;
    flush_eff = flush | (state == HOLD_FL);
    bubble    = flush_eff | pause;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= PC_RST;
      ex_r1_data <= '0;
      ex_r2_data <= '0;
      ex_imm     <= '0;
      ex_wa      <= '0;
      ex_we      <= 1'b0;
      ex_cregwd  <= '0;
      ex_aluop   <= '0;
      ex_memwe   <= 1'b0;
    end else if (load) begin
      if (bubble) begin
        ex_valid   <= 1'b0;
        ex_pc      <= '0;
        ex_r1_data <= '0;
        ex_r2_data <= '0;
        ex_imm     <= '0;
        ex_wa      <= '0;
        ex_we      <= 1'b0;
        ex_cregwd  <= '0;
        ex_aluop   <= '0;
        ex_memwe   <= 1'b0;
      end else begin
        // Write enables are qualified so an empty slot never looks like a producer.
        ex_valid   <= id_valid;
        ex_pc      <= id_pc;
        ex_r1_data <= id_r1_data;
        ex_r2_data <= id_r2_data;
        ex_imm     <= id_imm;
        ex_wa      <= id_wa;
        ex_we      <= id_we & id_valid;
        ex_cregwd  <= id_cregwd;
        ex_aluop   <= id_aluop;
        ex_memwe   <= id_memwe & id_valid;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  logic             cnt_stall, cnt_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign cnt_stall = load & pause & ~flush_eff;
  assign cnt_flush = load & flush_eff & id_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cnt_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (cnt_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign perf_stall = stall_cnt;
  assign perf_flush = flush_cnt;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule
